io_bridge: RTL and testbench
============================

// Module: io_bridge
// PURPOSE
//  Peripheral side of the core's IN/OUT ports: responder to the core's OUT writes and IN reads.
//  OUT path: each core OUT write pushes acc value into TX FIFO; external sink drains it via valid/ready.
//  IN path: external source pushes words via valid/ready into RX FIFO; core reads head on IN and pops it.
//  Sits between core and board-level I/O; decouples core timing from the external producer/consumer.
// PARAMETERS
//  NBITS       16  data word width (matches core ALU width)
//  DEPTH_LOG2  2   log2 of each FIFO depth (default 4 entries per FIFO)
// PORTS
//  clk        in   1      single system clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  out_wr     in   1      core OUT strobe: push out_data into TX FIFO this cycle
//  out_data   in   NBITS  core accumulator value to transmit
//  in_rd      in   1      core IN strobe: core consumes in_data this cycle, pop RX FIFO
//  in_data    out  NBITS  RX FIFO head to core (0 when RX empty)
//  tx_valid   out  1      TX FIFO non-empty
//  tx_data    out  NBITS  TX FIFO head
//  tx_ready   in   1      external sink accepts tx_data when tx_valid&tx_ready
//  rx_valid   in   1      external source offers rx_data
//  rx_data    in   NBITS  word from external source
//  rx_ready   out  1      RX FIFO not full
//  status     out  4      {tx_ovf, rx_unf, tx_full, rx_empty}
//  clr_flags  in   1      clears sticky tx_ovf/rx_unf
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): both FIFOs empty, pointers/counts 0, flags 0.
//   Outputs after reset: tx_valid=0, tx_data=0, rx_ready=1, in_data=0, status=4'b0001.
//  Reset mid-operation discards all queued words; in-flight handshakes are not completed.
//  FIFOs: circular buffers, DEPTH=2**DEPTH_LOG2, read/write pointers DEPTH_LOG2 bits wrap modulo DEPTH;
//   occupancy counter DEPTH_LOG2+1 bits distinguishes full from empty.
//  Head outputs (tx_data, in_data) are combinational from storage at read pointer; zero-latency view.
//  Push visible at head one cycle after the push edge (first word into empty FIFO).
//  TX path:
//   push = out_wr & (~tx_full | pop); pop = tx_valid & tx_ready.
//   out_wr while full and no pop: word dropped, tx_ovf set (sticky).
//   Full + out_wr + pop same cycle: both happen, count unchanged, no overflow.
//  RX path:
//   push = rx_valid & rx_ready; rx_ready = ~full (does not depend on in_rd, no comb loop).
//   pop = in_rd & ~rx_empty; in_rd while empty: no pointer change, in_data=0, rx_unf set (sticky).
//   Empty + rx push + in_rd same cycle: word is NOT bypassed; in_rd counts as underflow, word queued.
//  Flags: clr_flags clears tx_ovf/rx_unf at the edge; a new event in same cycle wins (flag stays 1).
//  tx_full/rx_empty in status are live (combinational from counts), not sticky.
//  Word values are passed unmodified; no width conversion.
// TESTING
//  Reset then idle -> tx_valid=0, rx_ready=1, in_data=0, status=4'b0001.
//  out_wr x3 (0x0011,0x0022,0x0033), tx_ready=1 after -> tx_data 0x0011,0x0022,0x0033 in order, then tx_valid=0.
//  out_wr x5 with tx_ready=0 (DEPTH 4) -> tx_full=1, 5th word dropped, tx_ovf=1; drain yields only first 4.
//  Full TX, out_wr=0xBEEF with tx_ready=1 same cycle -> count stays 4, no tx_ovf, 0xBEEF last out.
//  rx push 0xA5A5 then in_rd -> in_data=0xA5A5 during read cycle, then rx_empty=1; in_rd again -> rx_unf=1, in_data=0.
//  Fill RX to 4, rx_ready=0; assert rst_n=0 one cycle -> all empty, rx_ready=1, flags cleared.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: peripheral side of the core's IN/OUT ports.
// Core OUT writes queue into a TX FIFO that an external sink drains.
// An external source fills an RX FIFO that the core reads with IN.
//
// Handshake rule for both external ports: a word moves on a rising clk edge
// exactly when valid and ready are both 1 in that cycle. valid never depends
// on ready, and ready never depends on valid, so there is no combinational loop.
module io_bridge #(
    parameter int NBITS      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    // core OUT port
    input  logic             out_wr,
    input  logic [NBITS-1:0] out_data,
    // core IN port
    input  logic             in_rd,
    output logic [NBITS-1:0] in_data,
    // external sink (TX)
    output logic             tx_valid,
    output logic [NBITS-1:0] tx_data,
    input  logic             tx_ready,
    // external source (RX)
    input  logic             rx_valid,
    input  logic [NBITS-1:0] rx_data,
    output logic             rx_ready,
    // {tx_ovf, rx_unf, tx_full, rx_empty}
    output logic [3:0]       status,
    input  logic             clr_flags
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // TX FIFO state
    logic [NBITS-1:0]      tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [CW-1:0]         tx_count;

    // RX FIFO state
    logic [NBITS-1:0]      rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [CW-1:0]         rx_count;

    // sticky error flags
    logic tx_ovf;
    logic rx_unf;

    // derived controls
    logic tx_full;
    logic tx_empty;
    logic tx_push;
    logic tx_pop;
    logic tx_ovf_evt;
    logic rx_full;
    logic rx_empty;
    logic rx_push;
    logic rx_pop;
    logic rx_unf_evt;

    // Occupancy-derived status and handshake qualifiers for both FIFOs.
    always_comb begin
        tx_full    = (tx_count == FULL_CNT);
        tx_empty   = (tx_count == '0);
        tx_pop     = ~tx_empty & tx_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        tx_push    = out_wr & (~tx_full | tx_pop);
        tx_ovf_evt = out_wr & tx_full & ~tx_pop;

        rx_full    = (rx_count == FULL_CNT);
        rx_empty   = (rx_count == '0);
        rx_push    = rx_valid & ~rx_full;
        // No bypass: a read on an empty FIFO is an underflow even if a word
        // arrives in the same cycle; that word is simply queued.
        rx_pop     = in_rd & ~rx_empty;
        rx_unf_evt = in_rd & rx_empty;
    end

    // Head views are combinational; an empty FIFO shows zero rather than stale storage.
    always_comb begin
        tx_valid = ~tx_empty;
        tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
        in_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];
        rx_ready = ~rx_full;
        status   = {tx_ovf, rx_unf, tx_full, rx_empty};
    end

    // TX storage write; storage itself needs no reset since the head view is gated.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= out_data;
        end
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX storage write.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky flags: a fresh event outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (tx_ovf_evt)     tx_ovf <= 1'b1;
            else if (clr_flags) tx_ovf <= 1'b0;
            if (rx_unf_evt)     rx_unf <= 1'b1;
            else if (clr_flags) rx_unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: TX ordering, overflow, full+push+pop,
// RX read/underflow, no-bypass, flag clear priority, and reset discard.
module tb_io_bridge;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         out_wr;
    logic [W-1:0] out_data;
    logic         in_rd;
    logic [W-1:0] in_data;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         rx_ready;
    logic [3:0]   status;
    logic         clr_flags;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    io_bridge #(.NBITS(W), .DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .status    (status),
        .clr_flags (clr_flags)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        out_wr   = 1'b1;
        out_data = d;
        step();
        out_wr   = 1'b0;
    endtask

    task automatic rx_send(input logic [W-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        step();
        rx_valid = 1'b0;
    endtask

    // drain TX against the scoreboard, bounded in cycles
    task automatic tx_drain(input string tag);
        int budget;
        budget = 16;
        tx_ready = 1'b1;
        #1;
        while (exp_q.size() > 0 && budget > 0) begin
            check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
            check({tag, "_data"}, {16'd0, tx_data}, {16'd0, exp_q.pop_front()});
            step();
            budget--;
        end
        check({tag, "_budget"}, {31'd0, (budget > 0 || exp_q.size() == 0)}, 32'd1);
        tx_ready = 1'b0;
        #1;
        check({tag, "_empty"}, {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; out_wr = 1'b0; out_data = '0; in_rd = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; clr_flags = 1'b0;

        // reset then idle
        step();
        rst_n = 1'b1;
        step();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {16'd0, tx_data}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_in_data", {16'd0, in_data}, 32'd0);
        check("rst_status", {28'd0, status}, 32'h1);

        // three words out in order
        tx_write(16'h0011); exp_q.push_back(16'h0011);
        tx_write(16'h0022); exp_q.push_back(16'h0022);
        tx_write(16'h0033); exp_q.push_back(16'h0033);
        tx_drain("tx3");

        // five writes with sink stalled: fifth dropped, overflow set
        for (int i = 1; i <= 5; i++) begin
            tx_write(16'h1000 + 16'(i));
            if (i <= 4) exp_q.push_back(16'h1000 + 16'(i));
        end
        check("ovf_status", {28'd0, status}, 32'hB);

        // clear flags, TX stays full
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("clr_status", {28'd0, status}, 32'h3);

        // full FIFO with push and pop together
        out_wr   = 1'b1;
        out_data = 16'hBEEF;
        tx_ready = 1'b1;
        #1;
        check("fpp_head", {16'd0, tx_data}, {16'd0, exp_q.pop_front()});
        exp_q.push_back(16'hBEEF);
        step();
        out_wr   = 1'b0;
        tx_ready = 1'b0;
        check("fpp_status", {28'd0, status}, 32'h3);
        tx_drain("txf");

        // RX push then read
        rx_send(16'hA5A5);
        check("rx_head", {16'd0, in_data}, 32'hA5A5);
        check("rx_nonempty", {28'd0, status}, 32'h0);
        in_rd = 1'b1;
        #1;
        check("rx_rd_data", {16'd0, in_data}, 32'hA5A5);
        step();
        in_rd = 1'b0;
        check("rx_after_rd", {28'd0, status}, 32'h1);

        // read while empty: underflow
        in_rd = 1'b1;
        #1;
        check("unf_data", {16'd0, in_data}, 32'h0);
        step();
        in_rd = 1'b0;
        check("unf_status", {28'd0, status}, 32'h5);
        check("unf_data2", {16'd0, in_data}, 32'h0);

        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("unf_clr", {28'd0, status}, 32'h1);

        // empty + push + read same cycle: no bypass, underflow, word queued
        rx_valid = 1'b1;
        rx_data  = 16'h1234;
        in_rd    = 1'b1;
        #1;
        check("nb_data", {16'd0, in_data}, 32'h0);
        step();
        rx_valid = 1'b0;
        in_rd    = 1'b0;
        check("nb_status", {28'd0, status}, 32'h4);
        check("nb_head", {16'd0, in_data}, 32'h1234);

        // pop it, then underflow with clear in the same cycle: flag stays set
        in_rd = 1'b1;
        step();
        clr_flags = 1'b1;
        step();
        in_rd = 1'b0;
        clr_flags = 1'b0;
        check("clr_vs_evt", {28'd0, status}, 32'h5);

        // fill RX to full, check order and backpressure
        for (int i = 0; i < 4; i++) rx_send(16'hC000 + 16'(i));
        check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        rx_send(16'hDEAD);
        check("rx_full_head", {16'd0, in_data}, 32'hC000);
        in_rd = 1'b1;
        step();
        in_rd = 1'b0;
        check("rx_pop_head", {16'd0, in_data}, 32'hC001);
        check("rx_pop_ready", {31'd0, rx_ready}, 32'd1);
        rx_send(16'hC004);
        check("rx_refull", {31'd0, rx_ready}, 32'd0);

        // some TX content too, then reset mid-operation
        tx_write(16'h7777);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rr_status", {28'd0, status}, 32'h1);
        check("rr_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rr_in_data", {16'd0, in_data}, 32'h0);
        check("rr_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rr_tx_data", {16'd0, tx_data}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
